buffer_port_arbiter: RTL

- Shares one single-port buffer SRAM (ib/wb/ob buffer, active-low cenb/wenb, 1-cycle read latency) between two requesters: the matrix-mult core (core port) and the external host/test loader (ext port).
- Replaces the static ext_en_i mux in front of each buffer memory with per-cycle arbitration, burst locking and starvation protection, so the host can load or inspect a buffer while the core runs.
- One instance per buffer, between requesters and mem_emulator/SRAM macro.

---
 rtl/buffer_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/buffer_port_arbiter.sv
// buffer_port_arbiter
// Shares one single-port buffer SRAM (active-low cenb/wenb, 1-cycle read
// latency) between the matrix-mult core and the external host/test loader.
// Per-cycle arbitration with burst locking, fixed/round-robin priority and
// starvation protection. Memory-side signals are combinational from the
// winning port; read-valid flags are registered one cycle after the grant.

module buffer_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 512,
    parameter int MAX_WAIT = 8,
    localparam int AW      = $clog2(SIZE)
) (
    input  logic             clk_i,
    input  logic             rstn_sync_i,
    input  logic             ext_prio_i,
    // core requester
    input  logic             core_req_i,
    input  logic             core_lock_i,
    input  logic             core_we_i,
    input  logic [AW-1:0]    core_addr_i,
    input  logic [WIDTH-1:0] core_wdata_i,
    output logic             core_gnt_o,
    output logic             core_rvalid_o,
    // external host requester
    input  logic             ext_req_i,
    input  logic             ext_lock_i,
    input  logic             ext_we_i,
    input  logic [AW-1:0]    ext_addr_i,
    input  logic [WIDTH-1:0] ext_wdata_i,
    output logic             ext_gnt_o,
    output logic             ext_rvalid_o,
    // shared read data
    output logic [WIDTH-1:0] rdata_o,
    // memory side
    output logic             mem_cenb_o,
    output logic             mem_wenb_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [WIDTH-1:0] mem_d_o,
    input  logic [WIDTH-1:0] mem_q_i,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CORE_LOCK = 2'd1,
        EXT_LOCK  = 2'd2
    } state_t;

    localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic       last_ext_q;           // 1 = ext held the most recent grant
    logic [7:0] core_wait_q, ext_wait_q;
    logic [7:0] core_wait_d, ext_wait_d;
    logic       core_win, ext_win;
    logic       core_gnt, ext_gnt;
    logic       core_rvalid_q, ext_rvalid_q;

    // Pick a winner from the current requests and registered arbitration state.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
        core_win = 1'b0;
        ext_win  = 1'b0;
        unique case (state_q)
            CORE_LOCK: core_win = core_req_i;
            EXT_LOCK:  ext_win  = ext_req_i;
            default: begin
                if (core_req_i && ext_req_i) begin
                    if (core_wait_q == MAX_W8)     core_win = 1'b1;
                    else if (ext_wait_q == MAX_W8) ext_win  = 1'b1;
                    else if (ext_prio_i)           ext_win  = 1'b1;
                    else if (last_ext_q)           core_win = 1'b1;
                    else                           ext_win  = 1'b1;
                end else begin
                    core_win = core_req_i;
                    ext_win  = ext_req_i;
                end
            end
        endcase
    end

    // NOTE: reset is synchronous, so grants are also masked while it is low; a request seen in the reset cycle is never executed.
    assign core_gnt = core_win & rstn_sync_i;
    assign ext_gnt  = ext_win  & rstn_sync_i;

    // Saturating wait counters and next FSM state, including lock release and lock break.
    always_comb begin
        core_wait_d = 8'd0;
        ext_wait_d  = 8'd0;
        if (core_req_i && !core_gnt)
            core_wait_d = (core_wait_q == MAX_W8) ? MAX_W8 : core_wait_q + 8'd1;
        if (ext_req_i && !ext_gnt)
            ext_wait_d = (ext_wait_q == MAX_W8) ? MAX_W8 : ext_wait_q + 8'd1;

        state_d = state_q;
        unique case (state_q)
            CORE_LOCK: if (!core_lock_i || ext_wait_d == MAX_W8) state_d = IDLE;
            EXT_LOCK:  if (!ext_lock_i || core_wait_d == MAX_W8) state_d = IDLE;
            default: begin
                if (core_gnt && core_lock_i)     state_d = CORE_LOCK;
                else if (ext_gnt && ext_lock_i)  state_d = EXT_LOCK;
            end
        endcase
    end

    // Register arbitration state, wait counters and read-valid flags.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rstn_sync_i) begin
            state_q       <= IDLE;
            last_ext_q    <= 1'b1;
            core_wait_q   <= 8'd0;
            ext_wait_q    <= 8'd0;
            core_rvalid_q <= 1'b0;
            ext_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            core_wait_q   <= core_wait_d;
            ext_wait_q    <= ext_wait_d;
            core_rvalid_q <= core_gnt & ~core_we_i;
            ext_rvalid_q  <= ext_gnt & ~ext_we_i;
            if (core_gnt)     last_ext_q <= 1'b0;
            else if (ext_gnt) last_ext_q <= 1'b1;
        end
    end

    // Memory-side mux: driven from the granted port, idle values otherwise.
    always_comb begin
        mem_addr_o = '0;
        mem_d_o    = '0;
        if (core_gnt) begin
            mem_addr_o = core_addr_i;
            mem_d_o    = core_wdata_i;
        end else if (ext_gnt) begin
            mem_addr_o = ext_addr_i;
            mem_d_o    = ext_wdata_i;
        end
    end

    assign mem_cenb_o    = ~(core_gnt | ext_gnt);
    assign mem_wenb_o    = ~((core_gnt & core_we_i) | (ext_gnt & ext_we_i));
    assign core_gnt_o    = core_gnt;
    assign ext_gnt_o     = ext_gnt;
    assign core_rvalid_o = core_rvalid_q;
    assign ext_rvalid_o  = ext_rvalid_q;
    assign rdata_o       = mem_q_i;
    assign busy_o        = (state_q != IDLE);

endmodule
